// File: rtl/icache_pkg.sv
// Shared widths, address-field helpers and controller states for the
// direct-mapped instruction cache.
package icache_pkg;

  localparam int IC_DATA_WIDTH   = 32;
  localparam int IC_ADDR_WIDTH   = 16;
  localparam int IC_INDEX_WIDTH  = 3;
  localparam int IC_OFFSET_WIDTH = 5;
  localparam int IC_TAG_WIDTH    = IC_ADDR_WIDTH - IC_INDEX_WIDTH - IC_OFFSET_WIDTH;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_MISS_REQ,
    ST_FILL,
    ST_RESP
  } state_e;

  function automatic logic [IC_TAG_WIDTH-1:0] addr_tag(input logic [IC_ADDR_WIDTH-1:0] addr);
    return addr[IC_ADDR_WIDTH-1 -: IC_TAG_WIDTH];
  endfunction

  function automatic logic [IC_INDEX_WIDTH-1:0] addr_index(input logic [IC_ADDR_WIDTH-1:0] addr);
    return addr[IC_OFFSET_WIDTH +: IC_INDEX_WIDTH];
  endfunction

  function automatic logic [IC_OFFSET_WIDTH-1:0] addr_offset(input logic [IC_ADDR_WIDTH-1:0] addr);
    return addr[IC_OFFSET_WIDTH-1:0];
  endfunction

  // Line-aligned base address: tag and index kept, word offset zeroed.
  function automatic logic [IC_ADDR_WIDTH-1:0] block_base(input logic [IC_ADDR_WIDTH-1:0] addr);
    return {addr[IC_ADDR_WIDTH-1:IC_OFFSET_WIDTH], {IC_OFFSET_WIDTH{1'b0}}};
  endfunction

endpackage

// File: rtl/icache_data_store.sv
// Cache data array: one synchronous write port for refills, one
// combinational read port feeding the response register.
module icache_data_store #(
  parameter int DATA_WIDTH   = 32,
  parameter int INDEX_WIDTH  = 3,
  parameter int OFFSET_WIDTH = 5
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [INDEX_WIDTH-1:0]  wr_index,
  input  logic [OFFSET_WIDTH-1:0] wr_offset,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic [INDEX_WIDTH-1:0]  rd_index,
  input  logic [OFFSET_WIDTH-1:0] rd_offset,
  output logic [DATA_WIDTH-1:0]   rd_data
);

  localparam int DEPTH = 1 << (INDEX_WIDTH + OFFSET_WIDTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // NOTE: the array is deliberately not reset; per-line valid bits in the
  // top level guarantee stale contents are never returned.
  always_ff @(posedge clk) begin
    if (we) mem[{wr_index, wr_offset}] <= wr_data;
  end

  assign rd_data = mem[{rd_index, rd_offset}];

endmodule

// File: rtl/icache_direct.sv
// Direct-mapped read-only instruction cache: 1-cycle hits, whole-line
// refill from a streaming block-read memory controller on a miss.
module icache_direct
  import icache_pkg::*;
#(
  parameter int DATA_WIDTH   = IC_DATA_WIDTH,
  parameter int ADDR_WIDTH   = IC_ADDR_WIDTH,
  parameter int INDEX_WIDTH  = IC_INDEX_WIDTH,
  parameter int OFFSET_WIDTH = IC_OFFSET_WIDTH,
  parameter int TAG_WIDTH    = ADDR_WIDTH - INDEX_WIDTH - OFFSET_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cpu_req,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  output logic [DATA_WIDTH-1:0] cpu_data,
  output logic                  cpu_ready,
  input  logic                  flush,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_req,
  output logic                  mem_rw,
  input  logic [DATA_WIDTH-1:0] mem_data_read,
  input  logic                  mem_data_read_valid,
  input  logic                  mem_finished
);

  localparam int LINES      = 1 << INDEX_WIDTH;
  localparam int LINE_WORDS = 1 << OFFSET_WIDTH;
  localparam int CNT_W      = OFFSET_WIDTH + 1;

  state_e                state;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [LINES-1:0]      valid_q;
  logic [TAG_WIDTH-1:0]  tag_q [LINES];
  logic [CNT_W-1:0]      fill_cnt;
  logic                  flush_pending;

  logic [ADDR_WIDTH-1:0] look_addr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [DATA_WIDTH-1:0] resp_word;
  logic [CNT_W-1:0]      fill_cnt_next;
  logic                  hit_idle;
  logic                  fill_beat;
  logic                  line_full;
  logic                  fill_done;

  // In IDLE the live CPU address is looked up so a hit can be registered on
  // the sampling edge; afterwards the latched request address is used.
  assign look_addr = (state == ST_IDLE) ? cpu_addr : req_addr;

  assign hit_idle = !flush_pending
                 && valid_q[addr_index(cpu_addr)]
                 && (tag_q[addr_index(cpu_addr)] == addr_tag(cpu_addr));

  // Beats past a full line are dropped; the top bit of fill_cnt marks saturation.
  assign fill_beat     = (state == ST_FILL) && mem_data_read_valid && !fill_cnt[CNT_W-1];
  assign fill_cnt_next = fill_cnt + CNT_W'(fill_beat);
  assign line_full     = (fill_cnt_next == CNT_W'(LINE_WORDS));
  assign fill_done     = (state == ST_FILL) && mem_finished && line_full;

  // The requested word may arrive on the very beat that completes the refill.
  assign resp_word = (fill_beat && (fill_cnt[OFFSET_WIDTH-1:0] == addr_offset(req_addr)))
                   ? mem_data_read : rd_data;

  assign mem_rw = 1'b0;

  icache_data_store #(
    .DATA_WIDTH  (DATA_WIDTH),
    .INDEX_WIDTH (INDEX_WIDTH),
    .OFFSET_WIDTH(OFFSET_WIDTH)
  ) u_data_store (
    .clk      (clk),
    .we       (fill_beat),
    .wr_index (addr_index(req_addr)),
    .wr_offset(fill_cnt[OFFSET_WIDTH-1:0]),
    .wr_data  (mem_data_read),
    .rd_index (addr_index(look_addr)),
    .rd_offset(addr_offset(look_addr)),
    .rd_data  (rd_data)
  );

  always_ff @(posedge clk) begin
    if (fill_done) tag_q[addr_index(req_addr)] <= addr_tag(req_addr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      req_addr      <= '0;
      valid_q       <= '0;
      fill_cnt      <= '0;
      flush_pending <= 1'b0;
      cpu_ready     <= 1'b0;
      cpu_data      <= '0;
      mem_req       <= 1'b0;
      mem_addr      <= '0;
    end else begin
      // NOTE: pulse outputs default low every cycle with non-blocking
      // assignments; the case arms below only ever raise them.
      cpu_ready <= 1'b0;
      mem_req   <= 1'b0;

      if (flush && (state != ST_IDLE)) flush_pending <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (flush || flush_pending) begin
            valid_q       <= '0;
            flush_pending <= 1'b0;
          end
          if (!flush && cpu_req) begin
            req_addr <= cpu_addr;
            state    <= ST_LOOKUP;
            if (hit_idle) begin
              cpu_ready <= 1'b1;
              cpu_data  <= rd_data;
            end
          end
        end

        ST_LOOKUP: begin
          if (cpu_ready) begin
            state <= ST_IDLE;
          end else begin
            state    <= ST_MISS_REQ;
            mem_req  <= 1'b1;
            mem_addr <= block_base(req_addr);
          end
        end

        ST_MISS_REQ: begin
          valid_q[addr_index(req_addr)] <= 1'b0;
          fill_cnt                      <= '0;
          state                         <= ST_FILL;
        end

        ST_FILL: begin
          if (fill_beat) fill_cnt <= fill_cnt_next;
          if (mem_finished) begin
            if (line_full) begin
              valid_q[addr_index(req_addr)] <= 1'b1;
              cpu_ready                     <= 1'b1;
              cpu_data                      <= resp_word;
              state                         <= ST_RESP;
            end else begin
              // Short block: the line stays invalid and the whole read is retried.
              mem_req <= 1'b1;
              state   <= ST_MISS_REQ;
            end
          end
        end

        ST_RESP: state <= ST_IDLE;

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_icache_direct.sv
// Randomized scoreboard bench for icache_direct with a behavioural cache
// model and a streaming memory-controller responder.
module tb_icache_direct;

  logic        clk = 1'b0;
  logic        por_n = 1'b0;
  logic        abort_rst = 1'b0;
  logic        rst_n;
  logic        cpu_req = 1'b0;
  logic [15:0] cpu_addr = '0;
  logic [31:0] cpu_data;
  logic        cpu_ready;
  logic        drv_flush = 1'b0;
  logic        resp_flush = 1'b0;
  logic        flush;
  logic [15:0] mem_addr;
  logic        mem_req;
  logic        mem_rw;
  logic [31:0] mem_data_read = '0;
  logic        mem_data_read_valid = 1'b0;
  logic        mem_finished = 1'b0;

  assign rst_n = por_n & ~abort_rst;
  assign flush = drv_flush | resp_flush;

  always #5 clk = ~clk;

  icache_direct dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .cpu_req            (cpu_req),
    .cpu_addr           (cpu_addr),
    .cpu_data           (cpu_data),
    .cpu_ready          (cpu_ready),
    .flush              (flush),
    .mem_addr           (mem_addr),
    .mem_req            (mem_req),
    .mem_rw             (mem_rw),
    .mem_data_read      (mem_data_read),
    .mem_data_read_valid(mem_data_read_valid),
    .mem_finished       (mem_finished)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Backing memory contents: block 0x1220 holds 0xA000_0000 + offset,
  // other blocks are distinguished by the upper half of the word.
  function automatic logic [31:0] mem_word(input logic [15:0] a);
    logic [15:0] d;
    d = a ^ 16'h1220;
    return 32'hA000_0000 + {5'b0, d[15:5], 16'h0000} + {27'b0, d[4:0]};
  endfunction

  // Scoreboard queues and responder controls
  logic [31:0] exp_data_q[$];
  logic [15:0] exp_base_q[$];
  int mem_req_count = 0;
  int fetch_id = 0;
  int short_len = 0;
  int flush_at = -1;
  int abort_at = -1;

  // Behavioural cache model: which block each line currently holds
  logic [15:0] m_block [8];
  bit          m_valid [8];

  task automatic model_clear();
    for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
  endtask

  // Response monitor
  logic prev_mem_req = 1'b0;
  initial begin
    forever begin
      @(negedge clk);
      if (cpu_ready) begin
        if (exp_data_q.size() == 0) check("unexpected_cpu_ready", {31'b0, cpu_ready}, 32'd0);
        else check("cpu_data", cpu_data, exp_data_q.pop_front());
      end
      if (mem_req) begin
        check("mem_req_single_cycle", {31'b0, prev_mem_req}, 32'd0);
        check("mem_rw", {31'b0, mem_rw}, 32'd0);
      end
      prev_mem_req = mem_req;
    end
  end

  // Memory-controller responder: streams one block per mem_req pulse
  initial begin
    logic [15:0] base;
    int n;
    int seen_id;
    int refill_no;
    bit first;
    seen_id = -1;
    refill_no = 0;
    forever begin
      @(negedge clk);
      while (mem_req && rst_n) begin
        mem_req_count++;
        base = mem_addr;
        if (exp_base_q.size() == 0) check("unexpected_mem_req", {31'b0, mem_req}, 32'd0);
        else check("mem_addr", {16'b0, mem_addr}, {16'b0, exp_base_q.pop_front()});
        if (seen_id != fetch_id) begin
          seen_id = fetch_id;
          refill_no = 0;
        end
        first = (refill_no == 0);
        refill_no++;
        n = (first && short_len > 0) ? short_len : 32;
        @(negedge clk);
        for (int i = 0; i < n; ) begin
          if (first && i == abort_at) begin
            mem_data_read_valid = 1'b0;
            mem_finished = 1'b0;
            abort_rst = 1'b1;
            #1;
            check("abort_cpu_ready", {31'b0, cpu_ready}, 32'd0);
            check("abort_cpu_data", cpu_data, 32'd0);
            check("abort_mem_req", {31'b0, mem_req}, 32'd0);
            check("abort_mem_addr", {16'b0, mem_addr}, 32'd0);
            repeat (2) @(negedge clk);
            abort_rst = 1'b0;
            break;
          end
          if ($urandom_range(0, 3) == 0) begin
            mem_data_read_valid = 1'b0;
            mem_finished = 1'b0;
            mem_data_read = $urandom;
          end else begin
            mem_data_read = mem_word(base + 16'(i));
            mem_data_read_valid = 1'b1;
            mem_finished = (i == n - 1);
            if (first && i == flush_at) resp_flush = 1'b1;
            i++;
          end
          @(negedge clk);
          resp_flush = 1'b0;
        end
        mem_data_read_valid = 1'b0;
        mem_finished = 1'b0;
      end
    end
  end

  // One CPU fetch; hit/miss expectations come from the model.
  task automatic fetch(input logic [15:0] a, input int short_n, input int flush_k, input int abort_k);
    logic [2:0]  idx;
    logic [15:0] base;
    bit          hit;
    bit          aborted;
    int          exp_reqs;
    int          reqs0;
    int          cycles;
    idx     = a[7:5];
    base    = {a[15:5], 5'b0};
    hit     = m_valid[idx] && (m_block[idx] == base);
    aborted = 1'b0;
    if (hit) begin
      short_n = 0;
      flush_k = -1;
      abort_k = -1;
    end
    exp_reqs = hit ? 0 : ((short_n > 0) ? 2 : 1);
    repeat (exp_reqs) exp_base_q.push_back(base);
    if (abort_k < 0) exp_data_q.push_back(mem_word(a));
    short_len = short_n;
    flush_at  = flush_k;
    abort_at  = abort_k;
    fetch_id++;
    reqs0 = mem_req_count;

    @(negedge clk);
    cpu_req  = 1'b1;
    cpu_addr = a;
    cycles   = 0;
    forever begin
      @(negedge clk);
      cycles++;
      if (cpu_ready) break;
      if (abort_rst) begin
        aborted = 1'b1;
        break;
      end
      if (cycles > 3000) begin
        check("fetch_timeout", {31'b0, cpu_ready}, 32'd1);
        break;
      end
    end
    cpu_req = 1'b0;
    while (abort_rst) @(negedge clk);

    if (hit) check("hit_latency", cycles, 32'd1);
    check("mem_req_count", mem_req_count - reqs0, exp_reqs);

    if (aborted) begin
      model_clear();
    end else if (!hit) begin
      m_valid[idx] = 1'b1;
      m_block[idx] = base;
      if (flush_k >= 0) model_clear();
    end
    short_len = 0;
    flush_at  = -1;
    abort_at  = -1;
  endtask

  task automatic idle_flush();
    @(negedge clk);
    drv_flush = 1'b1;
    @(negedge clk);
    drv_flush = 1'b0;
    model_clear();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  tags [3];
    logic [15:0] a;
    int          sn;
    int          fk;
    tags[0] = 8'h12;
    tags[1] = 8'h52;
    tags[2] = 8'h7F;
    model_clear();

    repeat (3) @(negedge clk);
    check("reset_cpu_ready", {31'b0, cpu_ready}, 32'd0);
    check("reset_cpu_data", cpu_data, 32'd0);
    check("reset_mem_req", {31'b0, mem_req}, 32'd0);
    check("reset_mem_rw", {31'b0, mem_rw}, 32'd0);
    check("reset_mem_addr", {16'b0, mem_addr}, 32'd0);
    por_n = 1'b1;
    repeat (2) @(negedge clk);

    // Cold miss, hits, conflict eviction
    fetch(16'h1234, 0, -1, -1);
    fetch(16'h123F, 0, -1, -1);
    fetch(16'h1220, 0, -1, -1);
    fetch(16'h5234, 0, -1, -1);
    fetch(16'h1234, 0, -1, -1);
    // Short block with retry, then a hit on the retried line
    fetch(16'h2468, 20, -1, -1);
    fetch(16'h2468, 0, -1, -1);
    // Flush during fill: response delivered, next access misses
    fetch(16'h3000, 0, 5, -1);
    fetch(16'h3000, 0, -1, -1);
    // Reset mid-fill at word 10
    fetch(16'h4444, 0, -1, 10);
    fetch(16'h4444, 0, -1, -1);
    fetch(16'h2468, 0, -1, -1);
    // Flush while idle
    idle_flush();
    fetch(16'h4444, 0, -1, -1);

    for (int k = 0; k < 250; k++) begin
      a  = {tags[$urandom_range(0, 2)], 3'($urandom_range(0, 7)), 5'($urandom_range(0, 31))};
      sn = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 31)) : 0;
      fk = (sn == 0 && $urandom_range(0, 9) == 0) ? int'($urandom_range(0, 31)) : -1;
      if ($urandom_range(0, 14) == 0) idle_flush();
      fetch(a, sn, fk, -1);
    end

    repeat (5) @(negedge clk);
    check("data_queue_drained", exp_data_q.size(), 32'd0);
    check("mem_queue_drained", exp_base_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
